// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding and bus-width defaults.
// The decode-error pattern is what the register slave returns for unmapped addresses.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    localparam logic [31:0] APB_DECODE_ERR = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RDWAIT,
        RESP
    } apb_mst_state_e;

endpackage

// File: rtl/apb_cmd_master.sv
// Turns a valid/ready command stream into single APB transfers, one response per command.
// The slave has no pready, so read data is sampled a fixed RD_LAT cycles after ACCESS.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,

    output logic              busy
);

    // RD_LAT is at most 3, so the RDWAIT countdown never needs more than 2 bits.
    localparam logic [1:0] CNT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    apb_mst_state_e    state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rsp_write_d = cmd_write;
                    rsp_rdata_d = '0;
                    if (cmd_addr[1:0] != 2'b00) begin
                        // Misaligned: answer straight away, leave the bus untouched.
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        rsp_err_d = 1'b0;
                        psel_d    = 1'b1;
                        paddr_d   = cmd_addr;
                        pwrite_d  = cmd_write;
                        pwdata_d  = cmd_write ? cmd_wdata : '0;
                        state_d   = SETUP;
                    end
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (pwrite_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (RD_LAT == 0) begin
                    rsp_rdata_d = prdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = RDWAIT;
                end
            end

            RDWAIT: begin
                if (cnt_q == 2'd0) begin
                    rsp_rdata_d = prdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge value of every other.
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: cycle-level register slave on the APB side, transaction-level
// reference model (address maps in associative arrays) predicting every response.
module tb_apb_cmd_master;
    import apb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    localparam logic [31:0] ADDR_TBL [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20, 32'h14};

    logic        pclk = 1'b0;
    logic        preset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_paddr = '0;
    logic [31:0] exp_pwdata = '0;
    logic        exp_pwrite = 1'b0;

    always #5 pclk = ~pclk;

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .busy(busy)
    );

    // Register slave: 4-bit reg at 0x0, RW at 0x8/0xC, read-only at 0x4/0x10.
    // prdata is registered on the ACCESS edge and is valid for one cycle only; junk otherwise.
    logic [3:0]  slv_r0 = '0;
    logic [31:0] slv_r8 = '0;
    logic [31:0] slv_rc = '0;

    function automatic logic [31:0] slv_read(input logic [31:0] a);
        case (a)
            32'h00:  return {28'd0, slv_r0};
            32'h04:  return 32'h5A5A_5555;
            32'h08:  return slv_r8;
            32'h0C:  return slv_rc;
            32'h10:  return 32'h0000_FFFF;
            default: return APB_DECODE_ERR;
        endcase
    endfunction

    always @(posedge pclk) begin
        if (psel && penable && pwrite) begin
            case (paddr)
                32'h00:  slv_r0 <= pwdata[3:0];
                32'h08:  slv_r8 <= pwdata;
                32'h0C:  slv_rc <= pwdata;
                default: ;
            endcase
        end
        if (psel && penable && !pwrite) prdata <= slv_read(paddr);
        else                            prdata <= $urandom;
    end

    // Bus monitor: counts phases, remembers the last ACCESS, flags ordering violations.
    int          setup_cnt = 0;
    int          access_cnt = 0;
    int          proto_errs = 0;
    logic        was_setup = 1'b0;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_write;

    always @(posedge pclk) begin
        was_setup <= psel && !penable;
        if (psel && !penable) setup_cnt <= setup_cnt + 1;
        if (psel && penable) begin
            access_cnt <= access_cnt + 1;
            acc_addr   <= paddr;
            acc_write  <= pwrite;
            acc_wdata  <= pwdata;
            if (!was_setup) proto_errs <= proto_errs + 1;
        end
        if (penable && !psel) proto_errs <= proto_errs + 1;
    end

    // Reference model of the slave's address map.
    logic [31:0] m_val  [logic [31:0]];
    logic [31:0] m_mask [logic [31:0]];
    logic [31:0] m_rom  [logic [31:0]];

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (m_val.exists(a)) return m_val[a];
        if (m_rom.exists(a)) return m_rom[a];
        return APB_DECODE_ERR;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (m_mask.exists(a)) m_val[a] = d & m_mask[a];
    endtask

    task automatic model_init();
        m_mask[32'h0] = 32'h0000_000F;
        m_mask[32'h8] = 32'hFFFF_FFFF;
        m_mask[32'hC] = 32'hFFFF_FFFF;
        m_val[32'h0]  = 32'h0;
        m_val[32'h8]  = 32'h0;
        m_val[32'hC]  = 32'h0;
        m_rom[32'h4]  = 32'h5A5A_5555;
        m_rom[32'h10] = 32'h0000_FFFF;
    endtask

    // One full command/response transaction. Latency is the number of clock edges after the
    // accept edge at which rsp_valid is first seen: misaligned answers on the accept edge itself.
    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int hold, input bit junk, input string tag);
        logic        aligned;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_apb, lat, s0, a0, p0;
        bit          busy_bad, hold_bad;

        aligned   = (a[1:0] == 2'b00);
        exp_apb   = aligned ? 1 : 0;
        exp_lat   = !aligned ? 0 : (w ? 2 : 2 + RD_LAT);
        exp_rdata = (aligned && !w) ? model_read(a) : 32'h0;
        if (aligned && w) model_write(a, d);
        if (aligned) begin
            exp_paddr  = a;
            exp_pwrite = w;
            exp_pwdata = w ? d : 32'h0;
        end

        @(negedge pclk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_ready: got %b want 1", tag, cmd_ready);
        end
        s0 = setup_cnt; a0 = access_cnt; p0 = proto_errs;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge pclk);
        @(negedge pclk);
        if (junk) begin
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end else begin
            cmd_valid = 1'b0;
        end

        lat = 0; busy_bad = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            if (cmd_ready !== 1'b0 || busy !== 1'b1) busy_bad = 1;
            @(negedge pclk);
            lat++;
        end
        if (cmd_ready !== 1'b0 || busy !== 1'b1) busy_bad = 1;

        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        end
        vectors++;
        if (rsp_err !== !aligned) begin
            miscompares++;
            $display("FAIL %s rsp_err: got %b want %b", tag, rsp_err, !aligned);
        end
        vectors++;
        if (rsp_write !== w) begin
            miscompares++;
            $display("FAIL %s rsp_write: got %b want %b", tag, rsp_write, w);
        end
        vectors++;
        if (rsp_rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL %s rsp_rdata: got %h want %h", tag, rsp_rdata, exp_rdata);
        end

        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== !aligned ||
                rsp_write !== w || cmd_ready !== 1'b0 || busy !== 1'b1) hold_bad = 1;
        end
        vectors++;
        if (busy_bad || hold_bad) begin
            miscompares++;
            $display("FAIL %s busy_hold: got busy_bad=%0d hold_bad=%0d want 0/0", tag, busy_bad, hold_bad);
        end

        rsp_ready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;

        vectors++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL %s after_hs: got valid/ready/busy=%b want 010", tag, {rsp_valid, cmd_ready, busy});
        end
        vectors++;
        if (setup_cnt - s0 !== exp_apb || access_cnt - a0 !== exp_apb || proto_errs !== p0) begin
            miscompares++;
            $display("FAIL %s apb_phases: got setup=%0d access=%0d proto=%0d want %0d/%0d/0",
                     tag, setup_cnt - s0, access_cnt - a0, proto_errs - p0, exp_apb, exp_apb);
        end
        vectors++;
        if ({psel, penable} !== 2'b00 || paddr !== exp_paddr || pwrite !== exp_pwrite ||
            pwdata !== exp_pwdata) begin
            miscompares++;
            $display("FAIL %s bus_hold: got sel/en=%b addr=%h wr=%b wdata=%h want 00 %h %b %h",
                     tag, {psel, penable}, paddr, pwrite, pwdata, exp_paddr, exp_pwrite, exp_pwdata);
        end
        if (aligned) begin
            vectors++;
            if (acc_addr !== a || acc_write !== w || acc_wdata !== exp_pwdata) begin
                miscompares++;
                $display("FAIL %s access_fields: got %h %b %h want %h %b %h",
                         tag, acc_addr, acc_write, acc_wdata, a, w, exp_pwdata);
            end
        end
    endtask

    task automatic test_reset();
        #2 preset = 1'b1;
        repeat (3) @(negedge pclk);
        vectors++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_write, busy} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {psel, penable, pwrite, rsp_valid, rsp_err, rsp_write, busy});
        end
        vectors++;
        if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h want all zero", paddr, pwdata, rsp_rdata);
        end
        preset = 1'b0;
        @(negedge pclk);
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_rom_read();
        run_cmd(1'b0, 32'h4, 32'h0, 0, 1'b0, "rom_read");
    endtask

    task automatic test_write_read();
        run_cmd(1'b1, 32'h8, 32'hCAFE_F00D, 0, 1'b0, "wr8");
        run_cmd(1'b0, 32'h8, 32'h0, 0, 1'b0, "rd8");
    endtask

    task automatic test_mask_decode();
        run_cmd(1'b1, 32'h0, 32'hFFFF_FFFF, 1, 1'b0, "wr0_mask");
        run_cmd(1'b0, 32'h0, 32'h0, 0, 1'b0, "rd0_mask");
        run_cmd(1'b0, 32'h20, 32'h0, 0, 1'b0, "decode_err");
    endtask

    task automatic test_misaligned();
        run_cmd(1'b0, 32'h6, 32'h0, 0, 1'b0, "misalign_rd");
        run_cmd(1'b1, 32'h9, 32'h1111_2222, 2, 1'b0, "misalign_wr");
    endtask

    task automatic test_backpressure();
        run_cmd(1'b0, 32'h10, 32'h0, 5, 1'b1, "backpressure");
    endtask

    task automatic test_reset_mid_transfer();
        bit saw_valid;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'h1234_5678;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        vectors++;
        if ({psel, penable} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_mid in_access: got %b want 11", {psel, penable});
        end
        #1 preset = 1'b1;
        #1;
        vectors++;
        if ({psel, penable, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_mid async_drop: got sel/en/busy=%b want 000", {psel, penable, busy});
        end
        @(negedge pclk);
        preset = 1'b0;
        exp_paddr = '0; exp_pwrite = 1'b0; exp_pwdata = '0;
        saw_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (rsp_valid !== 1'b0) saw_valid = 1;
        end
        vectors++;
        if (saw_valid || cmd_ready !== 1'b1 || paddr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid aftermath: got saw_valid=%0d ready=%b paddr=%h want 0 1 0",
                     saw_valid, cmd_ready, paddr);
        end
        // The aborted write never reached the slave, so 0xC still holds its earlier value.
        run_cmd(1'b0, 32'hC, 32'h0, 0, 1'b0, "rst_readback");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          sel;
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 8);
            if (sel < 7) begin
                a = ADDR_TBL[sel];
            end else if (sel == 7) begin
                a = $urandom;
                a[1:0] = 2'b00;
            end else begin
                a = $urandom;
                a[1:0] = 2'($urandom_range(1, 3));
            end
            run_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_rom_read();
        test_write_read();
        test_mask_decode();
        test_misaligned();
        test_backpressure();
        test_reset_mid_transfer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
